// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES block-load controller.
// Holds the controller state encoding and the default values of the
// word width, words per 128-bit block and reg_full timeout.
package aes_ctrl_pkg;

  localparam int DW_DEF      = 32;
  localparam int N_WORDS_DEF = 4;
  localparam int TO_CYC_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    WAIT_FULL = 3'd2,
    OFFER     = 3'd3,
    READ      = 3'd4
  } state_t;

endpackage

// File: rtl/mod_blkload_ctrl_wdog_cnt.sv
// Watchdog counter used to bound the wait for reg_full.
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset
//   start  - count enable; one count per cycle while high
//   clear  - synchronous return to zero (dominates start)
//   expire - high in the LIMIT-th consecutive counted cycle
module mod_wdog_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt;

  // cnt holds the number of counted cycles already completed, so the
  // cycle in which it reads LIMIT-1 is the LIMIT-th one.
  assign expire = start && !clear && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mod_blkload_ctrl.sv
// Block-load controller: gathers N_WORDS upstream words into an external
// block register, waits for that register to report full, offers the block
// to the AES core, then reads and clears the register.
// Ports:
//   clk, resetn            - clock and asynchronous active-low reset
//   abort                  - synchronous flush, wins over everything else
//   in_valid/in_data       - upstream word; in_ready accepts it
//   reg_wr_en/idx/wdata    - registered write to the block register
//   reg_rd_en, reg_clr     - read strobe and one-cycle clear pulse
//   reg_full               - block register holds N_WORDS words
//   blk_valid/blk_ready    - block handshake with the AES core
//   busy                   - controller is not in IDLE
//   err_to                 - sticky reg_full timeout flag
module mod_blkload_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int TO_CYC  = TO_CYC_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          reg_wr_en,
  output logic [1:0]    reg_idx,
  output logic [DW-1:0] reg_wdata,
  output logic          reg_rd_en,
  output logic          reg_clr,
  input  logic          reg_full,
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic          busy,
  output logic          err_to
);

  // One extra count value so the counter can rest at N_WORDS without wrapping.
  localparam int CW = $clog2(N_WORDS + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          wr_nxt;
  logic          clr_nxt;
  logic          err_nxt;
  logic          accept;
  logic          wd_start;
  logic          wd_clear;
  logic          wd_expire;

  assign in_ready  = (state == IDLE) || ((state == FILL) && (count < CW'(N_WORDS)));
  assign accept    = in_valid && in_ready;
  assign blk_valid = (state == OFFER);
  assign reg_rd_en = (state == READ);
  assign busy      = (state != IDLE);

  // The watchdog only runs while we are waiting and reg_full is still low;
  // any other cycle (or an abort) restarts it from zero.
  assign wd_start = (state == WAIT_FULL) && !reg_full;
  assign wd_clear = !wd_start || abort;

  mod_wdog_cnt #(
    .LIMIT (TO_CYC)
  ) u_wdog (
    .clk    (clk),
    .resetn (resetn),
    .start  (wd_start),
    .clear  (wd_clear),
    .expire (wd_expire)
  );

  // State register plus the registered write/clear strobes and error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      count     <= '0;
      reg_wr_en <= 1'b0;
      reg_idx   <= 2'd0;
      reg_wdata <= '0;
      reg_clr   <= 1'b0;
      err_to    <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      reg_wr_en <= wr_nxt;
      reg_clr   <= clr_nxt;
      err_to    <= err_nxt;
      if (wr_nxt) begin
        reg_idx   <= count[1:0];
        reg_wdata <= in_data;
      end
    end
  end

  // Next-state logic. Abort is applied last so it overrides every other
  // decision made in the same cycle, including a coincident word accept.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wr_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    err_nxt   = err_to;

    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = FILL;
          count_nxt = CW'(1);
          wr_nxt    = 1'b1;
        end
      end
      FILL: begin
        if (accept) begin
          wr_nxt    = 1'b1;
          count_nxt = count + CW'(1);
          if (count == CW'(N_WORDS - 1)) begin
            state_nxt = WAIT_FULL;
          end
        end
      end
      WAIT_FULL: begin
        if (reg_full) begin
          state_nxt = OFFER;
        end else if (wd_expire) begin
          state_nxt = IDLE;
          count_nxt = '0;
          clr_nxt   = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      OFFER: begin
        if (blk_ready) begin
          state_nxt = READ;
        end
      end
      READ: begin
        state_nxt = IDLE;
        count_nxt = '0;
        clr_nxt   = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase

    if (abort) begin
      state_nxt = IDLE;
      count_nxt = '0;
      wr_nxt    = 1'b0;
      clr_nxt   = 1'b1;
      err_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_blkload_ctrl.sv
// Self-checking bench for mod_blkload_ctrl with a simple block-register model.
module tb_mod_blkload_ctrl;

  logic        clk;
  logic        resetn;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        reg_wr_en;
  logic [1:0]  reg_idx;
  logic [31:0] reg_wdata;
  logic        reg_rd_en;
  logic        reg_clr;
  logic        reg_full;
  logic        blk_valid;
  logic        blk_ready;
  logic        busy;
  logic        err_to;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int words     = 0;

  // Block register model: counts writes, cleared by reg_clr.
  int   nwr;
  logic full_en;

  mod_blkload_ctrl #(
    .DW      (32),
    .N_WORDS (4),
    .TO_CYC  (8)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reg_wr_en (reg_wr_en),
    .reg_idx   (reg_idx),
    .reg_wdata (reg_wdata),
    .reg_rd_en (reg_rd_en),
    .reg_clr   (reg_clr),
    .reg_full  (reg_full),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .busy      (busy),
    .err_to    (err_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) nwr <= 0;
    else if (reg_clr) nwr <= 0;
    else if (reg_wr_en && nwr < 4) nwr <= nwr + 1;
  end
  assign reg_full = full_en && (nwr == 4);

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of upstream traffic while the block is filling.
  task automatic drive_cycle(input logic v, input logic [31:0] d);
    logic acc;
    check("in_ready_fill", 32'(in_ready), 32'(words < 4));
    in_valid = v;
    in_data  = d;
    acc      = v && (words < 4);
    step();
    in_valid = 1'b0;
    check("wr_en", 32'(reg_wr_en), 32'(acc));
    if (acc) begin
      check("wr_idx", 32'(reg_idx), 32'(words));
      check("wr_data", reg_wdata, d);
      words++;
    end
  endtask

  task automatic wait_blk();
    int n = 0;
    while (blk_valid !== 1'b1 && n < 6) begin
      step();
      n++;
    end
    check("blk_valid_arrive", 32'(blk_valid), 32'd1);
  endtask

  task automatic handshake();
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    check("rd_en_pulse", 32'(reg_rd_en), 32'd1);
    check("blk_valid_after_hs", 32'(blk_valid), 32'd0);
    check("in_ready_read", 32'(in_ready), 32'd0);
    check("clr_in_read", 32'(reg_clr), 32'd0);
    step();
    check("rd_en_drop", 32'(reg_rd_en), 32'd0);
    check("clr_after_read", 32'(reg_clr), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    words = 0;
    step();
    check("clr_one_cycle", 32'(reg_clr), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(reg_wr_en), 32'd0);
    check({tag, "_rd_en"}, 32'(reg_rd_en), 32'd0);
    check({tag, "_clr"}, 32'(reg_clr), 32'd0);
    check({tag, "_idx"}, 32'(reg_idx), 32'd0);
    check({tag, "_wdata"}, reg_wdata, 32'd0);
    check({tag, "_blk_valid"}, 32'(blk_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_to"}, 32'(err_to), 32'd0);
  endtask

  initial begin
    logic [31:0] dir_words [4];
    logic        gap_pat [7];
    int          dly;
    int          guard;

    dir_words = '{32'h00f000f0, 32'h11221122, 32'h22222222, 32'h30303030};
    gap_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    resetn    = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    blk_ready = 1'b0;
    full_en   = 1'b1;

    // Reset state
    step();
    step();
    check_reset_outputs("rst");
    resetn = 1'b1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed block on consecutive cycles
    words = 0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, dir_words[i]);
    check("in_ready_after_4th", 32'(in_ready), 32'd0);
    check("busy_after_4th", 32'(busy), 32'd1);
    wait_blk();

    // Core stalls for 10 cycles; block must stay offered
    for (int i = 0; i < 10; i++) begin
      step();
      check("blk_valid_hold", 32'(blk_valid), 32'd1);
      check("rd_en_hold", 32'(reg_rd_en), 32'd0);
    end
    handshake();

    // reg_full never arrives: timeout after 8 waiting cycles
    full_en = 1'b0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, $urandom);
    for (int i = 0; i < 7; i++) begin
      step();
      check("to_busy_wait", 32'(busy), 32'd1);
      check("to_err_early", 32'(err_to), 32'd0);
    end
    step();
    check("to_err_set", 32'(err_to), 32'd1);
    check("to_clr", 32'(reg_clr), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    words = 0;
    step();
    full_en = 1'b1;
    check("to_err_sticky", 32'(err_to), 32'd1);
    check("to_clr_one_cycle", 32'(reg_clr), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_clears_err", 32'(err_to), 32'd0);
    check("abort_clr_pulse", 32'(reg_clr), 32'd1);
    step();

    // Abort coincident with the 3rd accept
    words = 0;
    drive_cycle(1'b1, $urandom);
    drive_cycle(1'b1, $urandom);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = $urandom;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_no_write", 32'(reg_wr_en), 32'd0);
    check("abort_clr", 32'(reg_clr), 32'd1);
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_blk_valid", 32'(blk_valid), 32'd0);
    words = 0;

    // Gapped upstream: count restarts at 0 after the abort
    for (int i = 0; i < 7; i++) drive_cycle(gap_pat[i], $urandom);
    check("gap_write_count", 32'(words), 32'd4);
    check("gap_in_ready_low", 32'(in_ready), 32'd0);
    wait_blk();
    handshake();

    // Random blocks with random gaps and random core stalls
    for (int b = 0; b < 4; b++) begin
      guard = 0;
      while (words < 4 && guard < 40) begin
        drive_cycle(1'($urandom_range(0, 1)), $urandom);
        guard++;
      end
      check("rnd_in_ready_low", 32'(in_ready), 32'd0);
      wait_blk();
      dly = $urandom_range(0, 5);
      for (int i = 0; i < dly; i++) begin
        step();
        check("rnd_blk_hold", 32'(blk_valid), 32'd1);
      end
      handshake();
    end

    // Asynchronous reset in the middle of a fill
    drive_cycle(1'b1, $urandom);
    drive_cycle(1'b1, $urandom);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    step();
    check_reset_outputs("mid_rst_held");
    resetn = 1'b1;
    check("in_ready_mid_rst", 32'(in_ready), 32'd1);
    words = 0;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, $urandom);
    wait_blk();
    handshake();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
